aes_inv_round: RTL and testbench
================================

# aes_inv_round

Single-round AES decryption datapath: applies InvShiftRows, InvSubBytes, AddRoundKey and, except on the final round, InvMixColumns to one 128-bit state per transaction. It is the decrypt-side counterpart of the cipher's forward row-shift/round logic. It sits in the aes_cipher decrypt path, driven once per round by the round controller, with the round key supplied by the key schedule. It carries a valid/ready handshake and sustains one round per clock.

## Interface
- DATA_WIDTH, 128, state width; only 128 is supported.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  data_in/round_key/last_round are valid.
- in_ready  output  1  block accepts an input this cycle.
- data_in  input  DATA_WIDTH  state entering the round.
- round_key  input  DATA_WIDTH  round key for AddRoundKey.
- last_round  input  1  1 = skip InvMixColumns (final decrypt round).
- out_valid  output  1  data_out is valid.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  DATA_WIDTH  round result.

## Operation
- Byte order: byte n = data[127-8n -: 8]; state s[r][c] = byte r+4c (FIPS-197 column-major).
- InvShiftRows: s'[r][(c+r) mod 4] = s[r][c]; row 0 unchanged, row r rotated right by r.
- InvSubBytes: FIPS-197 inverse S-box on every byte, purely combinational lookup.
- AddRoundKey: XOR with round_key, same byte order.
- InvMixColumns: per column, matrix {0e,0b,0d,09} rotated per row, over GF(2^8) with reduction polynomial 0x11b; the xtime chain is built from shifts and conditional XOR with 0x1b.
- last_round travels with its data through every pipeline stage. It is never sampled later than the capture cycle.
- Pipeline slots are valid-tagged registers. A slot loads when its upstream is valid and the slot is empty or draining in the same cycle.
- in_ready = !slot_full || out_ready for the input slot. This is combinational from out_ready and gives full throughput with no bubbles.
- Data, key and flag registers load only on a transfer (valid && ready). They hold while stalled.

## Timing
- Reset (async assert, sync-safe deassert): out_valid=0, data_out=0, all slot valid bits 0, in_ready=1 from the first cycle after reset is released.
- Latency from input transfer to out_valid: 1 cycle by default, 2 cycles with AES_INV_ROUND_PIPE_EN.
- Throughput: 1 transfer/cycle while out_ready=1.
- Stall: with out_ready=0 and the pipe full, in_ready=0. data_out and out_valid are held stable until the transfer completes.
- Simultaneous accept and drain when full: both occur in the same cycle, and the new data replaces the old on the next edge.
- Reset mid-operation: all in-flight data is discarded; no output is produced for it after reset.
- in_valid with no in_ready: no capture occurs; the upstream holds its inputs.

## Configuration
- AES_INV_ROUND_PIPE_EN defined: an extra register slot is placed after AddRoundKey, before InvMixColumns. Latency is 2 cycles and a second handshake slot is added; in_ready depends on slot-1 occupancy and back-pressure.
- Not defined: the whole round is combinational into a single output slot, with latency 1.
- Results, handshake rules and reset values are identical otherwise.

## Test plan
- Mid round (FIPS-197 C.1): data_in=7ad5fda789ef4e272bca100b3d9ff59f, round_key=549932d1f08557681093ed9cbe2c974e, last_round=0 -> data_out=54d990a16ba09ab596bbf40ea111702f after the configured latency.
- Last round: data_in=6353e08c0960e104cd70b751bacad0e7, round_key=000102030405060708090a0b0c0d0e0f, last_round=1 -> data_out=00112233445566778899aabbccddeeff.
- Back-to-back: the two vectors above on consecutive cycles with out_ready=1 -> both results on consecutive cycles in order, in_ready held 1 throughout.
- Back-pressure: out_ready=0 for 5 cycles with two inputs offered -> data_out is stable and in_ready drops once full; the inputs drain in order when out_ready=1, with nothing lost or duplicated.
- Reset mid-flight: assert rst the cycle after an input transfer -> out_valid=0 and data_out=0 immediately, and no stale output appears after release.
- Flag alignment: alternate last_round 0/1 on back-to-back vectors -> each output matches the flag captured with its own input. Compare against a software reference model on 1000 random states/keys.

Source files
------------

// File: rtl/aes_inv_round.sv
// aes_inv_round: one AES decryption round per transaction.
// Order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last_round=1).
// Optional feature macro: AES_INV_ROUND_PIPE_EN
//   undefined : whole round combinational into a single output slot, latency 1
//   defined   : extra slot after AddRoundKey, InvMixColumns in the second stage, latency 2
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready input handshake (in_ready combinational from out_ready)
//   data_in           128-bit state, byte n = data[127-8n -: 8], s[r][c] = byte r+4c
//   round_key         128-bit round key, same byte order
//   last_round        1 = final decrypt round, skip InvMixColumns
//   out_valid/out_ready output handshake
//   data_out          registered round result
module aes_inv_round #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] round_key,
  input  logic                  last_round,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  // FIPS-197 inverse S-box, entry 0 in the most significant byte
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x in GF(2^8) mod 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using the xtime chain
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] b2, b4, b8;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    return (c[0] ? b : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[3] ? b8 : 8'h00);
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey; row r rotates right by r
  function automatic logic [DATA_WIDTH-1:0] inv_rows_sub_key(input logic [DATA_WIDTH-1:0] s,
                                                             input logic [DATA_WIDTH-1:0] k);
    logic [0:NUM_BYTES-1][7:0] sb, kb, rb;
    sb = s;
    kb = k;
    rb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rb[r + 4*((c + r) % 4)] = INV_SBOX[sb[r + 4*c]] ^ kb[r + 4*((c + r) % 4)];
      end
    end
    return rb;
  endfunction

  // InvMixColumns: row r uses {0e,0b,0d,09} rotated right by r
  function automatic logic [DATA_WIDTH-1:0] inv_mix_columns(input logic [DATA_WIDTH-1:0] s);
    logic [0:NUM_BYTES-1][7:0] sb, rb;
    logic [0:3][3:0]           coef;
    sb   = s;
    coef = {4'he, 4'hb, 4'hd, 4'h9};
    rb   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        rb[r + 4*c] = gmul(sb[4*c],     coef[(4 - r) % 4]) ^ gmul(sb[4*c + 1], coef[(5 - r) % 4]) ^
                      gmul(sb[4*c + 2], coef[(6 - r) % 4]) ^ gmul(sb[4*c + 3], coef[(7 - r) % 4]);
      end
    end
    return rb;
  endfunction

  logic [DATA_WIDTH-1:0] ark_c;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

  assign ark_c     = inv_rows_sub_key(data_in, round_key);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

`ifdef AES_INV_ROUND_PIPE_EN
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_last_q, s1_last_d;
  logic                  s2_ready_c;

  assign s2_ready_c = !out_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_ready_c;

  // Slot 1 holds the AddRoundKey result and its flag; slot 2 holds the round output
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    if (s1_valid_q && s2_ready_c) begin
      out_valid_d = 1'b1;
      data_out_d  = s1_last_q ? s1_data_q : inv_mix_columns(s1_data_q);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (in_valid && in_ready) begin
      s1_valid_d = 1'b1;
      s1_data_d  = ark_c;
      s1_last_d  = last_round;
    end else if (s2_ready_c) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Single output slot: load on input transfer, empty when drained with nothing new
  always_comb begin
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      data_out_d  = last_round ? ark_c : inv_mix_columns(ark_c);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_inv_round.sv
// tb_aes_inv_round: directed vectors, handshake corner cases and a reference-model sweep for aes_inv_round.
module tb_aes_inv_round;

`ifdef AES_INV_ROUND_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;

  aes_inv_round #(.DATA_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .round_key(round_key), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [127:0] got_q[$];
  int           got_cyc[$];
  logic [127:0] exp_q[$];

  logic [7:0] isb [256];
  logic [7:0] cf  [4];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer (valid && ready seen mid-cycle)
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_q.push_back(data_out);
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'(v << n) | 8'(v >> (8 - n));
  endfunction

  // Builds the inverse S-box by inverting the forward S-box (GF inverse + affine)
  task automatic build_isb();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input logic l);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    logic [127:0] res;
    for (int n = 0; n < 16; n++) s[n] = d[127-8*n -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r + 4*((c + r) % 4)] = isb[s[r + 4*c]] ^ k[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[r + 4*c] = 8'h00;
        for (int j = 0; j < 4; j++) m[r + 4*c] = m[r + 4*c] ^ gf_mul(t[4*c + j], cf[(j - r + 4) % 4]);
      end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = l ? t[n] : m[n];
    return res;
  endfunction

  // ---------------- driving helpers ----------------
  // Called just after a rising edge; returns just after the edge on which the transfer happened
  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    in_valid = 1'b1; data_in = d; round_key = k; last_round = l;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = in_ready;
      n++;
    end
    if (!hs) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] d;
    logic [127:0] k;
    logic         l;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[6];

  localparam logic [127:0] MID_D = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] MID_K = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] MID_E = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] LST_D = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] LST_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] LST_E = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int   n;
    logic ov;
    logic done;
    logic [127:0] rd, rk;

    cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    // Constant columns of 0x52 are fixed points of InvMixColumns (0e^0b^0d^09 = 01)
    vecs[0] = '{"fips_mid",   MID_D, MID_K, 1'b0, MID_E};
    vecs[1] = '{"fips_last",  LST_D, LST_K, 1'b1, LST_E};
    vecs[2] = '{"zero_last",  '0, '0, 1'b1, {16{8'h52}}};
    vecs[3] = '{"zero_mid",   '0, '0, 1'b0, {16{8'h52}}};
    vecs[4] = '{"zero_keyff", '0, {16{8'hff}}, 1'b1, {16{8'had}}};
    vecs[5] = '{"s63_last",   {16{8'h63}}, '0, 1'b1, '0};

    rst = 1'b1; in_valid = 1'b0; data_in = '0; round_key = '0; last_round = 1'b0; out_ready = 1'b0;
    build_isb();

    // Reset state
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    check("post_rst_out_valid", 128'(out_valid), 128'd0);

    // Directed table with latency check
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].d, vecs[i].k, vecs[i].l);
      n = 0; ov = 1'b0;
      while (!ov && n < 10) begin
        @(negedge clk);
        ov = out_valid;
        n++;
      end
      check({vecs[i].name, "_latency"}, 128'(n), 128'(LAT));
      check(vecs[i].name, data_out, vecs[i].exp);
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back, in_ready held high
    got_q.delete(); got_cyc.delete();
    in_valid = 1'b1; data_in = MID_D; round_key = MID_K; last_round = 1'b0;
    @(negedge clk);
    check("b2b_ready_a", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    data_in = LST_D; round_key = LST_K; last_round = 1'b1;
    @(negedge clk);
    check("b2b_ready_b", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("b2b_count", 128'(got_q.size()), 128'd2);
    if (got_q.size() == 2) begin
      check("b2b_first", got_q[0], MID_E);
      check("b2b_second", got_q[1], LST_E);
      check("b2b_consecutive", 128'(got_cyc[1] - got_cyc[0]), 128'd1);
    end

    // Back-pressure: two inputs offered, output stalled for 5 cycles
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b0;
    fork
      begin
        send(MID_D, MID_K, 1'b0);
        send(LST_D, LST_K, 1'b1);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (out_valid) check("stall_hold", data_out, MID_E);
        end
        check("stall_in_ready", 128'(in_ready), 128'd0);
        check("stall_out_valid", 128'(out_valid), 128'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (LAT + 3) @(posedge clk);
    #1;
    check("bp_count", 128'(got_q.size()), 128'd2);
    if (got_q.size() == 2) begin
      check("bp_first", got_q[0], MID_E);
      check("bp_second", got_q[1], LST_E);
    end

    // Reset the cycle after an input transfer
    out_ready = 1'b0;
    send(MID_D, MID_K, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_data_out", data_out, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    got_q.delete(); got_cyc.delete();
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", 128'(got_q.size()), 128'd0);

    // Alternating last_round, random data/keys, random back-pressure
    got_q.delete(); got_cyc.delete(); exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          rd = {$urandom, $urandom, $urandom, $urandom};
          rk = {$urandom, $urandom, $urandom, $urandom};
          exp_q.push_back(ref_round(rd, rk, 1'(i % 2)));
          send(rd, rk, 1'(i % 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (got_q.size() < 1000 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("rand_count", 128'(got_q.size()), 128'd1000);
    for (int i = 0; i < 1000; i++) begin
      if (i < got_q.size()) check($sformatf("rand_%0d", i), got_q[i], exp_q[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
